led_sequencer: RTL and testbench

Controller that sequences the 6-LED display of the blinky design: it owns the step prescaler and decides when and how the LED pattern advances. It supports binary count, running-light and blink modes, with start/pause/stop/single-step control. It sits between the board push-button logic and the active-low LED pins.

---
 rtl/led_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_led_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// ---------------------------------------------------------------------------
// led_sequencer
//
// Sequences the 6-LED blinky display. It owns the step prescaler, and the
// prescaler decides when the LED pattern advances. There are three pattern
// modes: binary count, running light (shift) and blink. The sequencer takes
// start, pause, stop and single-step commands.
//
// Optional build macro: LED_SEQ_BOUNCE_EN
//   defined   : the shift mode ping-pongs between bit 0 and bit 5.
//   undefined : the shift mode wraps from bit 5 back to bit 0.
//               No direction register is built.
//
// Ports
//   clk      system clock; all logic runs on the rising edge
//   rst      synchronous reset, active low
//   start_i  pulse: IDLE -> RUN. The pattern mode is sampled from mode_i.
//   pause_i  pulse: toggles between RUN and PAUSE
//   stop_i   pulse: any state -> IDLE
//   step_i   pulse: in PAUSE, advance the pattern by one step
//   mode_i   pattern mode: 00 binary, 01 shift, 10 blink, 11 = binary
//   leds_o   LED drive, active low (~pattern)
//   busy_o   high in RUN or PAUSE
//   tick_o   one-cycle pulse in the first cycle that shows a new pattern
//   state_o  00 IDLE, 01 RUN, 10 PAUSE
//
// Command handshake: all commands are single-cycle pulses. There is no ready
// signal. A pulse that the current state does not accept is dropped. When
// several commands arrive in the same cycle, the priority is
// stop > start > pause > step.
// ---------------------------------------------------------------------------
module led_sequencer #(
  parameter int unsigned COUNT = 13500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic       stop_i,
  input  logic       step_i,
  input  logic [1:0] mode_i,
  output logic [5:0] leds_o,
  output logic       busy_o,
  output logic       tick_o,
  output logic [1:0] state_o
);

  localparam int unsigned PW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT - 1);

  localparam logic [1:0] MODE_BIN   = 2'b00;
  localparam logic [1:0] MODE_SHIFT = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  state_e        state_q;
  logic [1:0]    mode_q;
  logic [5:0]    pattern_q;
  logic [PW-1:0] presc_q;
  logic          tick_q;

  logic [5:0]    pattern_d;
  logic [1:0]    start_mode;
  logic [5:0]    start_pattern;

  // Mode 11 is folded into binary when it is captured, so the decode below
  // only has to handle three modes.
  assign start_mode    = (mode_i == 2'b11) ? MODE_BIN : mode_i;
  assign start_pattern = (start_mode == MODE_SHIFT) ? 6'h01 : 6'h00;

`ifdef LED_SEQ_BOUNCE_EN
  // dir_q: 0 = moving toward the MSB (left), 1 = moving toward the LSB.
  logic dir_q;
  logic dir_d;

  always_comb begin
    pattern_d = pattern_q + 6'd1;
    dir_d     = dir_q;
    case (mode_q)
      MODE_SHIFT: begin
        if (!dir_q) begin
          if (pattern_q == 6'h20) begin
            pattern_d = 6'h10;
            dir_d     = 1'b1;
          end else begin
            pattern_d = pattern_q << 1;
          end
        end else begin
          if (pattern_q == 6'h01) begin
            pattern_d = 6'h02;
            dir_d     = 1'b0;
          end else begin
            pattern_d = pattern_q >> 1;
          end
        end
      end
      MODE_BLINK: pattern_d = ~pattern_q;
      default:    pattern_d = pattern_q + 6'd1;
    endcase
  end
`else
  always_comb begin
    pattern_d = pattern_q + 6'd1;
    case (mode_q)
      MODE_SHIFT: pattern_d = (pattern_q == 6'h20) ? 6'h01 : (pattern_q << 1);
      MODE_BLINK: pattern_d = ~pattern_q;
      default:    pattern_d = pattern_q + 6'd1;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_BIN;
      pattern_q <= 6'h00;
      presc_q   <= '0;
      tick_q    <= 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
      dir_q     <= 1'b0;
`endif
    end else begin
      // tick is a pulse. Only an advance in this cycle raises it again.
      tick_q <= 1'b0;
      if (stop_i) begin
        state_q   <= ST_IDLE;
        pattern_q <= 6'h00;
        presc_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              state_q   <= ST_RUN;
              mode_q    <= start_mode;
              presc_q   <= '0;
              pattern_q <= start_pattern;
`ifdef LED_SEQ_BOUNCE_EN
              dir_q     <= 1'b0;
`endif
            end
          end
          ST_RUN: begin
            if (pause_i) begin
              // The prescaler is not incremented on the pause edge. The
              // held value is the value the count resumes from.
              state_q <= ST_PAUSE;
            end else if (presc_q == PRESC_MAX) begin
              presc_q   <= '0;
              pattern_q <= pattern_d;
              tick_q    <= 1'b1;
`ifdef LED_SEQ_BOUNCE_EN
              dir_q     <= dir_d;
`endif
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
          ST_PAUSE: begin
            if (pause_i) begin
              state_q <= ST_RUN;
            end else if (step_i) begin
              pattern_q <= pattern_d;
              tick_q    <= 1'b1;
`ifdef LED_SEQ_BOUNCE_EN
              dir_q     <= dir_d;
`endif
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign leds_o  = ~pattern_q;
  assign busy_o  = (state_q != ST_IDLE);
  assign tick_o  = tick_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_led_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_sequencer
//
// Directed bench for led_sequencer, built with COUNT = 4. Every expected
// pattern below was worked out by hand from the sequencing rules. Inputs are
// driven 1 ns after each rising edge. Outputs are sampled at the same point,
// so every check sees the state that the preceding edge left behind.
// ---------------------------------------------------------------------------
module tb_led_sequencer;

  localparam int unsigned COUNT = 4;

  logic       clk;
  logic       rst;
  logic       start_i;
  logic       pause_i;
  logic       stop_i;
  logic       step_i;
  logic [1:0] mode_i;
  logic [5:0] leds_o;
  logic       busy_o;
  logic       tick_o;
  logic [1:0] state_o;

  int n_vec;
  int n_err;

  led_sequencer #(.COUNT(COUNT)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .pause_i (pause_i),
    .stop_i  (stop_i),
    .step_i  (step_i),
    .mode_i  (mode_i),
    .leds_o  (leds_o),
    .busy_o  (busy_o),
    .tick_o  (tick_o),
    .state_o (state_o)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cmds();
    start_i = 1'b0;
    pause_i = 1'b0;
    stop_i  = 1'b0;
    step_i  = 1'b0;
  endtask

  task automatic send_start(input logic [1:0] mode);
    mode_i  = mode;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  task automatic send_stop();
    stop_i = 1'b1;
    cyc();
    stop_i = 1'b0;
  endtask

  // Expect n-1 quiet cycles, then one cycle with tick_o high and the
  // pattern exp_pat on the LED pins.
  task automatic wait_tick(input int n, input logic [5:0] exp_pat, input string tag);
    for (int i = 0; i < n - 1; i++) begin
      cyc();
      check_eq({tag, "_quiet"}, {31'd0, tick_o}, 32'd0);
    end
    cyc();
    check_eq({tag, "_tick"}, {31'd0, tick_o}, 32'd1);
    check_eq({tag, "_leds"}, {26'd0, leds_o}, {26'd0, ~exp_pat});
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_state"}, {30'd0, state_o}, 32'd0);
    check_eq({tag, "_busy"},  {31'd0, busy_o},  32'd0);
    check_eq({tag, "_tick"},  {31'd0, tick_o},  32'd0);
    check_eq({tag, "_leds"},  {26'd0, leds_o},  32'h3F);
  endtask

  initial begin
    logic [5:0] shift_seq [12];
    n_vec = 0;
    n_err = 0;

    // Reset with random inputs
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_i = 1'($urandom_range(0, 1));
      pause_i = 1'($urandom_range(0, 1));
      stop_i  = 1'($urandom_range(0, 1));
      step_i  = 1'($urandom_range(0, 1));
      mode_i  = 2'($urandom_range(0, 3));
      cyc();
    end
    check_idle("reset");
    clear_cmds();
    mode_i = 2'b00;
    rst = 1'b1;
    cyc();
    check_idle("post_reset");

    // Binary count
    send_start(2'b00);
    check_eq("bin_start_state", {30'd0, state_o}, 32'd1);
    check_eq("bin_start_busy",  {31'd0, busy_o},  32'd1);
    check_eq("bin_start_leds",  {26'd0, leds_o},  32'h3F);
    check_eq("bin_start_tick",  {31'd0, tick_o},  32'd0);
    for (int k = 1; k <= 3; k++) wait_tick(COUNT, 6'(k), "bin");
    check_eq("bin_after3", {26'd0, leds_o}, 32'h3C);
    for (int k = 4; k <= 64; k++) wait_tick(COUNT, 6'(k), "bin");
    check_eq("bin_wrap", {26'd0, leds_o}, 32'h3F);
    send_stop();
    check_idle("bin_stop");

    // Shift
`ifdef LED_SEQ_BOUNCE_EN
    shift_seq = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h10,
                  6'h08, 6'h04, 6'h02, 6'h01, 6'h02, 6'h04};
`else
    shift_seq = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01,
                  6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
`endif
    send_start(2'b01);
    check_eq("shift_init", {26'd0, leds_o}, 32'h3E);
    for (int k = 0; k < 12; k++) wait_tick(COUNT, shift_seq[k], "shift");
    send_stop();
    check_idle("shift_stop");

    // Pause / step / resume (binary)
    send_start(2'b00);
    wait_tick(COUNT, 6'h01, "ps_first");
    cyc();
    cyc();
    pause_i = 1'b1;
    cyc();
    pause_i = 1'b0;
    check_eq("pause_state", {30'd0, state_o}, 32'd2);
    check_eq("pause_busy",  {31'd0, busy_o},  32'd1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check_eq("pause_no_tick", {31'd0, tick_o}, 32'd0);
      check_eq("pause_leds",    {26'd0, leds_o}, 32'h3E);
    end
    step_i = 1'b1;
    cyc();
    step_i = 1'b0;
    check_eq("step_tick",  {31'd0, tick_o},  32'd1);
    check_eq("step_leds",  {26'd0, leds_o},  32'h3D);
    check_eq("step_state", {30'd0, state_o}, 32'd2);
    cyc();
    check_eq("step_tick_end", {31'd0, tick_o}, 32'd0);
    // A start while paused is ignored.
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    check_eq("pause_start_ign", {30'd0, state_o}, 32'd2);
    pause_i = 1'b1;
    cyc();
    pause_i = 1'b0;
    check_eq("resume_state", {30'd0, state_o}, 32'd1);
    wait_tick(2, 6'h03, "resume");
    wait_tick(COUNT, 6'h04, "resume_next");

    // Stop and start together while running: stop has priority.
    stop_i  = 1'b1;
    start_i = 1'b1;
    mode_i  = 2'b01;
    cyc();
    clear_cmds();
    check_idle("stop_start");
    // Start alone, blink mode. Changing mode_i later has no effect.
    send_start(2'b10);
    check_eq("blink_state", {30'd0, state_o}, 32'd1);
    check_eq("blink_init",  {26'd0, leds_o},  32'h3F);
    mode_i = 2'b01;
    wait_tick(COUNT, 6'h3F, "blink1");
    wait_tick(COUNT, 6'h00, "blink2");
    send_stop();

    // Mode 11 behaves as binary.
    send_start(2'b11);
    check_eq("m3_init", {26'd0, leds_o}, 32'h3F);
    wait_tick(COUNT, 6'h01, "m3_a");
    wait_tick(COUNT, 6'h02, "m3_b");

    // Reset pulse while the prescaler sits at COUNT-1.
    cyc();
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    check_idle("rst_mid");
    for (int i = 0; i < 6; i++) cyc();
    check_idle("rst_stay");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
